// File: rtl/mem_access_unit.sv
// EX/MEM memory access stage: passes ALU results to write-back and runs one
// lane-aligned data-memory transaction at a time, with alignment and timeout faults.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [2:0]          ex_op,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [4:0]          ex_dest,
  output logic                ex_ready,
  output logic                dm_req,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W/8-1:0] dm_be,
  input  logic                dm_ack,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_data,
  output logic [4:0]          wb_dest,
  output logic                misaligned,
  output logic                bus_err
);

  localparam int NB     = DATA_W / 8;
  localparam int L      = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int AW_EXT = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  localparam logic [2:0] OP_ALU = 3'd0;
  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LB  = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  function automatic logic is_aligned(input logic [2:0] op, input logic [L-1:0] off);
    case (op)
      OP_LW, OP_SW:         is_aligned = (off == L'(0));
      OP_LH, OP_LHU, OP_SH: is_aligned = (off[0] == 1'b0);
      default:              is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [2:0] op, input logic [L-1:0] off);
    case (op)
      OP_LW, OP_SW:         lane_be = {NB{1'b1}};
      OP_LH, OP_LHU, OP_SH: lane_be = NB'(2'b11) << off;
      default:              lane_be = NB'(1'b1) << off;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] op, input logic [DATA_W-1:0] data);
    case (op)
      OP_SB:   store_lanes = {NB{data[7:0]}};
      OP_SH:   store_lanes = {(NB/2){data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] op, input logic [L-1:0] off,
                                                     input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (op)
      OP_LB:   load_extract = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      OP_LH:   load_extract = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      OP_LHU:  load_extract = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [2:0]          op_r, op_nxt_s;
  logic [L-1:0]        off_r, off_nxt_s;
  logic [4:0]          dest_r, dest_nxt_s;

  logic                dm_req_nxt_s, dm_we_nxt_s;
  logic [ADDR_W-1:0]   dm_addr_nxt_s;
  logic [DATA_W-1:0]   dm_wdata_nxt_s;
  logic [NB-1:0]       dm_be_nxt_s;
  logic                wb_valid_nxt_s;
  logic [DATA_W-1:0]   wb_data_nxt_s;
  logic [4:0]          wb_dest_nxt_s;
  logic                misaligned_nxt_s, bus_err_nxt_s;

  logic [AW_EXT-1:0]   res_ext_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [L-1:0]        off_s;
  logic                accept_s, is_mem_s, is_store_s, aligned_s, timeout_s;

  assign res_ext_s  = AW_EXT'(ex_result);
  assign addr_s     = res_ext_s[ADDR_W-1:0];
  assign off_s      = addr_s[L-1:0];
  assign ex_ready   = (state_r == ST_IDLE);
  assign accept_s   = ex_valid && ex_ready;
  assign is_mem_s   = (ex_op != OP_ALU);
  assign is_store_s = (ex_op >= OP_SW);
  assign aligned_s  = is_aligned(ex_op, off_s);
  // The last WAIT cycle is the one whose count would reach TIMEOUT; a same-cycle ack wins.
  assign timeout_s  = (state_r == ST_WAIT) && !dm_ack && (cnt_r == CNT_LAST);

  // State, counter, transaction context and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_W'(0);
      op_r       <= 3'd0;
      off_r      <= L'(0);
      dest_r     <= 5'd0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= ADDR_W'(0);
      dm_wdata   <= DATA_W'(0);
      dm_be      <= NB'(0);
      wb_valid   <= 1'b0;
      wb_data    <= DATA_W'(0);
      wb_dest    <= 5'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      op_r       <= op_nxt_s;
      off_r      <= off_nxt_s;
      dest_r     <= dest_nxt_s;
      dm_req     <= dm_req_nxt_s;
      dm_we      <= dm_we_nxt_s;
      dm_addr    <= dm_addr_nxt_s;
      dm_wdata   <= dm_wdata_nxt_s;
      dm_be      <= dm_be_nxt_s;
      wb_valid   <= wb_valid_nxt_s;
      wb_data    <= wb_data_nxt_s;
      wb_dest    <= wb_dest_nxt_s;
      misaligned <= misaligned_nxt_s;
      bus_err    <= bus_err_nxt_s;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mem_s && aligned_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_W'(0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dm_ack || timeout_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_W'(0);
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_W'(0);
      end
    endcase
  end

  // Next values of outputs and captured load context; non-pulse outputs hold by default.
  always_comb begin
    op_nxt_s         = op_r;
    off_nxt_s        = off_r;
    dest_nxt_s       = dest_r;
    dm_req_nxt_s     = dm_req;
    dm_we_nxt_s      = dm_we;
    dm_addr_nxt_s    = dm_addr;
    dm_wdata_nxt_s   = dm_wdata;
    dm_be_nxt_s      = dm_be;
    wb_valid_nxt_s   = 1'b0;
    wb_data_nxt_s    = wb_data;
    wb_dest_nxt_s    = wb_dest;
    misaligned_nxt_s = 1'b0;
    bus_err_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !is_mem_s) begin
          wb_valid_nxt_s = 1'b1;
          wb_data_nxt_s  = ex_result;
          wb_dest_nxt_s  = ex_dest;
        end else if (accept_s && !aligned_s) begin
          misaligned_nxt_s = 1'b1;
        end else if (accept_s) begin
          dm_req_nxt_s   = 1'b1;
          dm_we_nxt_s    = is_store_s;
          dm_addr_nxt_s  = addr_s & ~LANE_MASK;
          dm_be_nxt_s    = lane_be(ex_op, off_s);
          dm_wdata_nxt_s = store_lanes(ex_op, ex_store_data);
          op_nxt_s       = ex_op;
          off_nxt_s      = off_s;
          dest_nxt_s     = ex_dest;
        end else begin
          dm_req_nxt_s   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dm_ack) begin
          dm_req_nxt_s = 1'b0;
          if (op_r < OP_SW) begin
            wb_valid_nxt_s = 1'b1;
            wb_data_nxt_s  = load_extract(op_r, off_r, dm_rdata);
            wb_dest_nxt_s  = dest_r;
          end else begin
            wb_valid_nxt_s = 1'b0;
          end
        end else if (timeout_s) begin
          dm_req_nxt_s  = 1'b0;
          bus_err_nxt_s = 1'b1;
        end else begin
          dm_req_nxt_s  = 1'b1;
        end
      end
      default: begin
        dm_req_nxt_s = 1'b0;
      end
    endcase
  end

endmodule
